// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback and traps faults.
// Define CONTROL_FSM_PERF_EN to build the cycle_cnt/instret_cnt performance counters.
module control_fsm #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned WAIT_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_wren,
   output logic             addr_sel,
   output logic             ir_wren,
   output logic             pc_inc,
   output logic             alu_src_imm,
   output logic             regfile_wren,
   output logic             wb_sel_mem,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [WIDTH-1:0] cycle_cnt,
   output logic [WIDTH-1:0] instret_cnt
);

   localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);

   localparam logic [6:0] OpReg   = 7'b0110011;
   localparam logic [6:0] OpImm   = 7'b0010011;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMemAddr,
      StMemRead,
      StMemWrite,
      StWriteback,
      StFault
   } state_e;

   state_e          r_state;
   state_e          w_next;
   logic [CntW-1:0] r_wait;
   logic [CntW-1:0] w_wait_next;
   logic [1:0]      r_cause;
   logic [1:0]      w_cause_next;
   logic            r_wb_mem;
   logic            w_waiting;
   logic            w_timeout;

   assign w_waiting = (r_state == StFetch) || (r_state == StMemRead) || (r_state == StMemWrite);
   assign w_timeout = w_waiting && !mem_ready && (r_wait == CntW'(WAIT_TIMEOUT));

   // State register plus the small amount of state that travels with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= StIdle;
         r_wait   <= '0;
         r_cause  <= 2'b00;
         r_wb_mem <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         r_cause <= w_cause_next;
         if (w_next == StWriteback) begin
            r_wb_mem <= (r_state == StMemRead);
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cause_next = r_cause;
      // Counter only runs while a request is stalled; any completion or other state clears it.
      w_wait_next  = (w_waiting && !mem_ready && !w_timeout) ? r_wait + CntW'(1) : '0;
      case (r_state)
         StIdle:      w_next = StFetch;
         StFetch: begin
            if (mem_ready) begin
               w_next = StDecode;
            end else if (w_timeout) begin
               w_next       = StFault;
               w_cause_next = 2'b10;
            end
         end
         StDecode: begin
            case (opcode)
               OpReg, OpImm, OpLui: w_next = StExec;
               OpLoad, OpStore:     w_next = StMemAddr;
               default: begin
                  w_next       = StFault;
                  w_cause_next = 2'b01;
               end
            endcase
         end
         StExec:      w_next = StWriteback;
         StMemAddr:   w_next = (opcode == OpLoad) ? StMemRead : StMemWrite;
         StMemRead: begin
            if (mem_ready) begin
               w_next = StWriteback;
            end else if (w_timeout) begin
               w_next       = StFault;
               w_cause_next = 2'b10;
            end
         end
         StMemWrite: begin
            if (mem_ready) begin
               w_next = StFetch;
            end else if (w_timeout) begin
               w_next       = StFault;
               w_cause_next = 2'b10;
            end
         end
         StWriteback: w_next = StFetch;
         StFault:     w_next = StFault;
         default:     w_next = StIdle;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_wren     = 1'b0;
      addr_sel     = 1'b0;
      ir_wren      = 1'b0;
      pc_inc       = 1'b0;
      alu_src_imm  = 1'b0;
      regfile_wren = 1'b0;
      wb_sel_mem   = 1'b0;
      fault        = 1'b0;
      case (r_state)
         StFetch: begin
            mem_req = 1'b1;
            ir_wren = mem_ready;
            pc_inc  = mem_ready;
         end
         StExec:      alu_src_imm = (opcode == OpImm) || (opcode == OpLui);
         StMemAddr: begin
            alu_src_imm = 1'b1;
            addr_sel    = 1'b1;
         end
         StMemRead: begin
            mem_req     = 1'b1;
            addr_sel    = 1'b1;
            alu_src_imm = 1'b1;
         end
         StMemWrite: begin
            mem_req     = 1'b1;
            mem_wren    = 1'b1;
            addr_sel    = 1'b1;
            alu_src_imm = 1'b1;
         end
         StWriteback: begin
            regfile_wren = 1'b1;
            wb_sel_mem   = r_wb_mem;
         end
         StFault:     fault = 1'b1;
         default:     ;
      endcase
   end

   assign fault_cause = r_cause;

`ifdef CONTROL_FSM_PERF_EN
   logic [WIDTH-1:0] r_cycle_cnt;
   logic [WIDTH-1:0] r_instret_cnt;
   logic             w_retire;

   assign w_retire = (r_state == StWriteback) || ((r_state == StMemWrite) && mem_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if ((r_state != StIdle) && (r_state != StFault)) begin
            r_cycle_cnt <= r_cycle_cnt + WIDTH'(1);
         end
         if (w_retire) begin
            r_instret_cnt <= r_instret_cnt + WIDTH'(1);
         end
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: queue-based instruction-plan model, random and directed stimulus.
`timescale 1ns/1ps
module tb_control_fsm;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned TO    = 4;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcode;
   logic             mem_ready;
   logic             mem_req, mem_wren, addr_sel, ir_wren, pc_inc;
   logic             alu_src_imm, regfile_wren, wb_sel_mem, fault;
   logic [1:0]       fault_cause;
   logic [WIDTH-1:0] cycle_cnt, instret_cnt;

   always #5 clk = ~clk;

   control_fsm #(
      .WIDTH        (WIDTH),
      .WAIT_TIMEOUT (TO)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_wren     (mem_wren),
      .addr_sel     (addr_sel),
      .ir_wren      (ir_wren),
      .pc_inc       (pc_inc),
      .alu_src_imm  (alu_src_imm),
      .regfile_wren (regfile_wren),
      .wb_sel_mem   (wb_sel_mem),
      .fault        (fault),
      .fault_cause  (fault_cause),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // One step of an instruction's plan; outs = {req, wren, addr_sel, alu_imm, rf_wren, wb_mem}.
   typedef struct packed {
      logic [5:0] outs;
      logic       waits;
      logic       retires;
      logic       fetch;
      logic       decode;
   } step_t;

   step_t       m_q[$];
   bit          m_idle, m_fault, new_op;
   logic [1:0]  m_cause;
   int          m_wait;
   logic [31:0] m_cyc, m_ret;
   logic [6:0]  m_op, op_pick;

   logic [10:0] s_out;
   logic [31:0] s_cyc, s_ret;

   function automatic step_t mk(input logic [5:0] o, input logic w, input logic r,
                                input logic f, input logic d);
      return {o, w, r, f, d};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return (op == OP_REG) || (op == OP_IMM) || (op == OP_LUI) || (op == OP_LOAD) ||
             (op == OP_STORE);
   endfunction

   function automatic logic [10:0] out_vec();
      return {mem_req, mem_wren, addr_sel, ir_wren, pc_inc, alu_src_imm, regfile_wren,
              wb_sel_mem, fault, fault_cause};
   endfunction

   function automatic logic [10:0] m_expect();
      step_t s;
      logic  f;
      if (m_idle || m_fault || m_q.size() == 0) return {8'b0, m_fault, m_cause};
      s = m_q[0];
      f = s.fetch & mem_ready;
      return {s.outs[5:3], f, f, s.outs[2:0], 3'b000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_plan(input logic [6:0] op);
      m_q.push_back(mk(6'b000000, 1'b0, 1'b0, 1'b0, 1'b1));
      case (op)
         OP_REG: begin
            m_q.push_back(mk(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0));
            m_q.push_back(mk(6'b000010, 1'b0, 1'b1, 1'b0, 1'b0));
         end
         OP_IMM, OP_LUI: begin
            m_q.push_back(mk(6'b000100, 1'b0, 1'b0, 1'b0, 1'b0));
            m_q.push_back(mk(6'b000010, 1'b0, 1'b1, 1'b0, 1'b0));
         end
         OP_LOAD: begin
            m_q.push_back(mk(6'b001100, 1'b0, 1'b0, 1'b0, 1'b0));
            m_q.push_back(mk(6'b101100, 1'b1, 1'b0, 1'b0, 1'b0));
            m_q.push_back(mk(6'b000011, 1'b0, 1'b1, 1'b0, 1'b0));
         end
         OP_STORE: begin
            m_q.push_back(mk(6'b001100, 1'b0, 1'b0, 1'b0, 1'b0));
            m_q.push_back(mk(6'b111100, 1'b1, 1'b1, 1'b0, 1'b0));
         end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_q.delete();
      m_idle  = 1'b1;
      m_fault = 1'b0;
      m_cause = 2'b00;
      m_wait  = 0;
      m_cyc   = '0;
      m_ret   = '0;
      new_op  = 1'b0;
   endtask

   task automatic model_step();
      step_t s;
      if (m_fault) return;
      if (m_idle) begin
         m_idle = 1'b0;
         m_q.push_back(mk(6'b100000, 1'b1, 1'b0, 1'b1, 1'b0));
         m_wait = 0;
         return;
      end
      m_cyc++;
      s = m_q[0];
      if (s.waits && !mem_ready) begin
         if (m_wait == TO) begin
            m_fault = 1'b1;
            m_cause = 2'b10;
            m_q.delete();
         end else begin
            m_wait++;
         end
         return;
      end
      void'(m_q.pop_front());
      m_wait = 0;
      if (s.retires) m_ret++;
      if (s.fetch) begin
         m_op   = op_pick;
         new_op = 1'b1;
         m_plan(op_pick);
      end
      if (s.decode && !is_legal(m_op)) begin
         m_fault = 1'b1;
         m_cause = 2'b01;
         m_q.delete();
      end
      if (!m_fault && m_q.size() == 0) m_q.push_back(mk(6'b100000, 1'b1, 1'b0, 1'b1, 1'b0));
   endtask

   // Called at posedge+1; applies mem_ready for one cycle and snapshots outputs mid-cycle.
   task automatic cyc(input logic rdy);
      mem_ready = rdy;
      #3;
      s_out = out_vec();
      s_cyc = cycle_cnt;
      s_ret = instret_cnt;
      @(posedge clk);
      if (rst) model_step();
      #1;
      if (new_op) begin
         opcode = m_op;
         new_op = 1'b0;
      end
   endtask

   task automatic reset_seq();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst    = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("outputs", {53'b0, out_vec()}, {53'b0, m_expect()});
`ifdef CONTROL_FSM_PERF_EN
            chk("cycle_cnt", {32'b0, cycle_cnt}, {32'b0, m_cyc});
            chk("instret_cnt", {32'b0, instret_cnt}, {32'b0, m_ret});
`else
            chk("cycle_cnt", {32'b0, cycle_cnt}, 64'd0);
            chk("instret_cnt", {32'b0, instret_cnt}, 64'd0);
`endif
         end
      end
   end

   logic [15:0] h_ir, h_rf, h_req, h_wb;
   int          cnt, bad, fault_age, pct;
   logic [31:0] r_exp_one, c_exp_eight, c_exp_two;

   initial begin
      rst       = 1'b0;
      mem_ready = 1'b0;
      opcode    = '0;
      op_pick   = OP_REG;
      m_op      = OP_REG;
      model_reset();
`ifdef CONTROL_FSM_PERF_EN
      r_exp_one   = 32'd1;
      c_exp_eight = 32'd8;
      c_exp_two   = 32'd2;
`else
      r_exp_one   = 32'd0;
      c_exp_eight = 32'd0;
      c_exp_two   = 32'd0;
`endif
      @(posedge clk);
      #1;
      reset_seq();
      chk("reset_outputs", {53'b0, out_vec()}, 64'd0);
      chk("reset_counters", {cycle_cnt, instret_cnt}, 64'd0);

      // OP, zero wait: IDLE FETCH DECODE EXEC WB FETCH
      op_pick = OP_REG;
      h_ir = '0; h_rf = '0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1);
         h_ir[k] = s_out[7];
         h_rf[k] = s_out[4];
      end
      chk("op_ir_wren_pattern", {48'b0, h_ir}, 64'h22);
      chk("op_regfile_pulse", {48'b0, h_rf}, 64'h10);

      // LOAD with three stalled read cycles
      reset_seq();
      op_pick = OP_LOAD;
      h_req = '0; h_wb = '0; bad = 0;
      for (int k = 0; k < 10; k++) begin
         cyc((k >= 4 && k <= 6) ? 1'b0 : 1'b1);
         h_req[k] = s_out[10];
         h_wb[k]  = s_out[3];
         if (s_out[2]) bad++;
      end
      chk("load_mem_req_pattern", {48'b0, h_req}, 64'h2F2);
      chk("load_wb_sel_mem", {48'b0, h_wb}, 64'h100);
      chk("load_no_fault", bad, 0);
      chk("load_instret", {32'b0, s_ret}, {32'b0, r_exp_one});
      chk("load_cycle_cnt", {32'b0, s_cyc}, {32'b0, c_exp_eight});

      // STORE, zero wait
      reset_seq();
      op_pick = OP_STORE;
      h_ir = '0; h_rf = '0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1);
         h_ir[k] = s_out[7];
         h_rf[k] = s_out[4];
         if (k == 4) chk("store_mem_write", {61'b0, s_out[10:8]}, 64'h7);
      end
      chk("store_ir_wren_pattern", {48'b0, h_ir}, 64'h22);
      chk("store_no_regfile", {48'b0, h_rf}, 64'h0);
      chk("store_instret", {32'b0, s_ret}, {32'b0, r_exp_one});

      // Illegal opcode then 100 cycles of toggling mem_ready
      reset_seq();
      op_pick = 7'h7F;
      cyc(1'b1); cyc(1'b1); cyc(1'b1);
      op_pick = OP_REG;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         cyc(k[0]);
         if (s_out !== 11'b00000000101) bad++;
      end
      chk("illegal_fault_hold", bad, 0);
      chk("illegal_cycle_freeze", {32'b0, s_cyc}, {32'b0, c_exp_two});

      // Fetch timeout on the fifth stalled cycle
      reset_seq();
      cyc(1'b1);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0);
         cnt += int'(s_out[10]);
      end
      chk("timeout_req_cycles", cnt, 5);
      chk("timeout_not_early", {63'b0, s_out[2]}, 64'd0);
      cyc(1'b0);
      chk("timeout_fault", {61'b0, s_out[2:0]}, 64'h6);

      // Completion on that same cycle wins
      reset_seq();
      cyc(1'b1);
      for (int k = 0; k < 4; k++) cyc(1'b0);
      cyc(1'b1);
      chk("ready_wins_ir", {63'b0, s_out[7]}, 64'd1);
      cyc(1'b1);
      chk("ready_wins_decode", {53'b0, s_out}, 64'd0);

      // Reset dropped while a store waits in MEM_WRITE
      reset_seq();
      op_pick = OP_STORE;
      cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      mem_ready = 1'b0;
      #2;
      chk("store_wait_before_rst", {61'b0, mem_req, mem_wren, addr_sel}, 64'h7);
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_rst_outputs", {53'b0, out_vec()}, 64'd0);
      chk("async_rst_counters", {cycle_cnt, instret_cnt}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1);
      chk("after_rst_idle", {53'b0, s_out}, 64'd0);
      cyc(1'b1);
      chk("after_rst_fetch", {63'b0, s_out[10]}, 64'd1);

      // Randomised traffic against the model
      fault_age = 0;
      for (int i = 0; i < 4000; i++) begin
         case ((i / 500) % 3)
            0:       pct = 95;
            1:       pct = 60;
            default: pct = 20;
         endcase
         case ($urandom_range(0, 19))
            0, 1, 2, 3:     op_pick = OP_REG;
            4, 5, 6:        op_pick = OP_IMM;
            7, 8:           op_pick = OP_LUI;
            9, 10, 11, 12:  op_pick = OP_LOAD;
            13, 14, 15, 16: op_pick = OP_STORE;
            default: begin
               op_pick = 7'($urandom);
               if (is_legal(op_pick)) op_pick = 7'h7F;
            end
         endcase
         fault_age = m_fault ? fault_age + 1 : 0;
         if (fault_age > 15) begin
            reset_seq();
         end else if ($urandom_range(0, 299) == 0) begin
            mem_ready = 1'($urandom);
            #2;
            rst = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            rst = 1'b1;
         end else begin
            cyc(1'($urandom_range(0, 99) < pct));
         end
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle control unit for the RV32I core; sits directly upstream of the datapath and drives its enables (ir_wren, pc_inc, regfile_wren) plus memory/mux selects.
- Consumes the decoded opcode the datapath exports from its instruction register.
- Sequences fetch/decode/execute/memory/writeback, handles memory wait states via a ready handshake, and traps illegal opcodes and memory timeouts into a sticky fault state.

Parameters:
- WIDTH, 32, width of performance counters (cycle_cnt, instret_cnt).
- WAIT_TIMEOUT, 255, maximum consecutive memory wait count before fault; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = in reset).
- opcode  input  7  rv32i opcode from the datapath IR (instruction[6:0]).
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_wren  output  1  request is a write (valid only with mem_req).
- addr_sel  output  1  0 = memory address from PC, 1 = from ALU result.
- ir_wren  output  1  load instruction register.
- pc_inc  output  1  advance PC by 4.
- alu_src_imm  output  1  ALU B operand = immediate instead of regfile_b.
- regfile_wren  output  1  write regfile.
- wb_sel_mem  output  1  writeback data = memory read data (else ALU).
- fault  output  1  sticky fault flag.
- fault_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout.
- cycle_cnt  output  WIDTH  cycles executed (see Optional Feature).
- instret_cnt  output  WIDTH  instructions retired (see Optional Feature).

Behaviour:
- Reset (rst low, async): state=IDLE, wait counter=0, fault=0, fault_cause=00, counters=0; all outputs 0.
- Outputs decoded from state (Moore), except ir_wren/pc_inc in FETCH, which are qualified by mem_ready (Mealy).
- Recognised opcodes: OP 0110011, OP_IMM 0010011, LUI 0110111, LOAD 0000011, STORE 0100011.
- IDLE: all outputs 0; next = FETCH unconditionally (first edge after reset release).
- FETCH:
  - mem_req=1, addr_sel=0, mem_wren=0.
  - If mem_ready: ir_wren=1 and pc_inc=1 in that cycle; next = DECODE. Otherwise stay.
- DECODE: no outputs.
  - OP, OP_IMM, LUI → EXEC.
  - LOAD, STORE → MEM_ADDR.
  - Any other value → FAULT, fault_cause=01.
- EXEC: alu_src_imm=1 if opcode is OP_IMM or LUI, else 0; next = WRITEBACK.
- MEM_ADDR: alu_src_imm=1, addr_sel=1; LOAD → MEM_READ, STORE → MEM_WRITE.
- MEM_READ:
  - mem_req=1, addr_sel=1, alu_src_imm=1.
  - On mem_ready → WRITEBACK with wb_sel_mem latched to 1.
- MEM_WRITE:
  - mem_req=1, mem_wren=1, addr_sel=1, alu_src_imm=1.
  - On mem_ready → FETCH; retires the instruction.
- WRITEBACK: regfile_wren=1 for exactly one cycle; wb_sel_mem=1 only when arriving from MEM_READ; retires the instruction; next = FETCH.
- opcode is stable from DECODE through WRITEBACK because ir_wren is only asserted in FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ, or MEM_WRITE.
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - If counter==WAIT_TIMEOUT and mem_ready=0 → FAULT, fault_cause=10. The fault is therefore taken after WAIT_TIMEOUT+1 consecutive non-ready cycles.
  - If mem_ready=1 on that same cycle, the completion wins and no fault is raised.
- FAULT:
  - All control outputs 0; fault=1; fault_cause held.
  - Sticky: only rst exits. mem_ready is ignored.
- Reset mid-operation (including mid memory wait): immediate return to IDLE, no partial writes. regfile_wren and mem_wren drop asynchronously with rst.
- Retire event: the WRITEBACK cycle, or the MEM_WRITE cycle with mem_ready=1. Exactly one per instruction.
- Latency with zero-wait memory (mem_ready always 1), counted from FETCH to next FETCH:
  - OP: 4 cycles (FETCH, DECODE, EXEC, WRITEBACK).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.

Optional Feature:
- Macro CONTROL_FSM_PERF_EN.
- Defined:
  - cycle_cnt increments every cycle the state is not IDLE or FAULT.
  - instret_cnt increments on each retire event.
  - Both wrap modulo 2^WIDTH and freeze in FAULT.
- Undefined: both ports tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset then mem_ready=1 constantly, opcode=0110011 → state sequence IDLE,FETCH,DECODE,EXEC,WRITEBACK,FETCH; regfile_wren high 1 cycle; ir_wren/pc_inc high 1 cycle in FETCH.
- LOAD with mem_ready low for 3 cycles in MEM_READ → mem_req held 4 cycles; WRITEBACK with wb_sel_mem=1; instret_cnt +1 (PERF_EN); fault=0.
- STORE, zero-wait → MEM_WRITE shows mem_req=1, mem_wren=1, addr_sel=1; returns to FETCH with no regfile_wren pulse; instret_cnt +1.
- Opcode 1111111 at DECODE → FAULT, fault=1, fault_cause=01; holds all outputs 0 for 100 cycles despite mem_ready toggling.
- WAIT_TIMEOUT=4, mem_ready=0 in FETCH → fault on 5th request cycle, fault_cause=10. Repeat with mem_ready=1 on the 5th cycle → DECODE, no fault.
- Drop rst while in MEM_WRITE waiting → outputs 0 immediately; counters 0; after release, IDLE then FETCH on next edge.
